// File: rtl/indicador_jogador.sv
// Turn/phase tracker feeding the letter-J and player-digit hex decoders.
// Optional INDICADOR_ALTERNA_INICIO_EN: alternate the starting player per game.
module indicador_jogador #(
   parameter int PERIODO_PISCA = 25000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada_valida,
   input  logic       fim_vitoria,
   input  logic       fim_empate,
   output logic       habilita_J,
   output logic       jogador_atual,
   output logic [3:0] numero_jogador,
   output logic       fim_jogo
);

   localparam int LARG = $clog2(PERIODO_PISCA);
   localparam logic [LARG-1:0] ULTIMO = LARG'(PERIODO_PISCA - 1);
   localparam logic [LARG-1:0] UM = LARG'(1);

   typedef enum logic [1:0] {
      OCIOSO  = 2'b00,
      JOGANDO = 2'b01,
      VITORIA = 2'b10,
      EMPATE  = 2'b11
   } estado_t;

   estado_t         estado;
   estado_t         estado_prox;
   logic            jogador_prox;
   logic [LARG-1:0] contador;
   logic [LARG-1:0] contador_prox;
   logic            fase_pisca;
   logic            fase_prox;
   logic            jogador_inicial;

`ifdef INDICADOR_ALTERNA_INICIO_EN
   logic inicio_prox;
   logic inicio_prox_n;

   assign jogador_inicial = inicio_prox;

   always_ff @(posedge clock) begin
      if (reset) begin
         inicio_prox <= 1'b0;
      end else begin
         inicio_prox <= inicio_prox_n;
      end
   end

   always_comb begin
      inicio_prox_n = inicio_prox;
      if (iniciar) begin
         inicio_prox_n = ~inicio_prox;
      end
   end
`else
   assign jogador_inicial = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         estado        <= OCIOSO;
         jogador_atual <= 1'b0;
         contador      <= '0;
         fase_pisca    <= 1'b1;
      end else begin
         estado        <= estado_prox;
         jogador_atual <= jogador_prox;
         contador      <= contador_prox;
         fase_pisca    <= fase_prox;
      end
   end

   // iniciar wins in every state, so it is handled ahead of the state decode
   always_comb begin
      estado_prox   = estado;
      jogador_prox  = jogador_atual;
      contador_prox = '0;
      fase_prox     = fase_pisca;
      if (iniciar) begin
         estado_prox  = JOGANDO;
         jogador_prox = jogador_inicial;
         fase_prox    = 1'b1;
      end else begin
         unique case (estado)
            OCIOSO: begin
            end
            JOGANDO: begin
               if (fim_vitoria) begin
                  estado_prox = VITORIA;
                  fase_prox   = 1'b1;
               end else if (fim_empate) begin
                  estado_prox = EMPATE;
               end else if (jogada_valida) begin
                  jogador_prox = ~jogador_atual;
               end
            end
            VITORIA: begin
               if (contador == ULTIMO) begin
                  fase_prox = ~fase_pisca;
               end else begin
                  contador_prox = contador + UM;
               end
            end
            EMPATE: begin
            end
            default: begin
               estado_prox = OCIOSO;
            end
         endcase
      end
   end

   always_comb begin
      habilita_J     = 1'b0;
      numero_jogador = 4'd0;
      fim_jogo       = 1'b0;
      unique case (estado)
         OCIOSO: begin
         end
         JOGANDO: begin
            habilita_J     = 1'b1;
            numero_jogador = jogador_atual ? 4'd2 : 4'd1;
         end
         VITORIA: begin
            habilita_J     = fase_pisca;
            numero_jogador = jogador_atual ? 4'd2 : 4'd1;
            fim_jogo       = 1'b1;
         end
         EMPATE: begin
            fim_jogo = 1'b1;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_indicador_jogador.sv
// Bench for indicador_jogador: directed plan steps plus random traffic
// checked against a game-level reference model.
module tb_indicador_jogador;

   localparam int P = 4;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       jogada_valida = 1'b0;
   logic       fim_vitoria = 1'b0;
   logic       fim_empate = 1'b0;
   logic       habilita_J;
   logic       jogador_atual;
   logic [3:0] numero_jogador;
   logic       fim_jogo;

   int comparacoes = 0;
   int erros = 0;

   // model: phase 0 idle, 1 playing, 2 won, 3 draw
   int m_fase = 0;
   int m_jog = 0;
   int m_ciclos = 0;
   int m_jogos = 0;

   indicador_jogador #(.PERIODO_PISCA(P)) dut (
      .clock          (clock),
      .reset          (reset),
      .iniciar        (iniciar),
      .jogada_valida  (jogada_valida),
      .fim_vitoria    (fim_vitoria),
      .fim_empate     (fim_empate),
      .habilita_J     (habilita_J),
      .jogador_atual  (jogador_atual),
      .numero_jogador (numero_jogador),
      .fim_jogo       (fim_jogo)
   );

   always #5 clock = ~clock;

   task automatic confere(input string tag, input int obs, input int esp);
      comparacoes++;
      assert (obs === esp) else begin
         erros++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, esp);
      end
   endtask

   task automatic novo_jogo();
      m_fase = 1;
`ifdef INDICADOR_ALTERNA_INICIO_EN
      m_jog = m_jogos % 2;
      m_jogos++;
`else
      m_jog = 0;
`endif
   endtask

   task automatic modelo(input bit r, input bit i, input bit jv,
                         input bit fv, input bit fe);
      if (r) begin
         m_fase = 0; m_jog = 0; m_ciclos = 0; m_jogos = 0;
      end else if (i) begin
         novo_jogo();
      end else if (m_fase == 1) begin
         if (fv) begin
            m_fase = 2; m_ciclos = 0;
         end else if (fe) begin
            m_fase = 3;
         end else if (jv) begin
            m_jog = 1 - m_jog;
         end
      end else if (m_fase == 2) begin
         m_ciclos++;
      end
   endtask

   task automatic ciclo(input string tag, input bit r, input bit i,
                        input bit jv, input bit fv, input bit fe);
      int hab;
      int num;
      reset = r; iniciar = i; jogada_valida = jv;
      fim_vitoria = fv; fim_empate = fe;
      @(posedge clock);
      modelo(r, i, jv, fv, fe);
      #1;
      hab = (m_fase == 1) ? 1 :
            (m_fase == 2) ? (((m_ciclos / P) % 2) == 0 ? 1 : 0) : 0;
      num = (m_fase == 1 || m_fase == 2) ? m_jog + 1 : 0;
      confere({tag, ".hab"}, int'(habilita_J), hab);
      confere({tag, ".num"}, int'(numero_jogador), num);
      confere({tag, ".fim"}, int'(fim_jogo), (m_fase >= 2) ? 1 : 0);
      confere({tag, ".jog"}, int'(jogador_atual), m_jog);
   endtask

   initial begin
      #2;
      ciclo("rst0", 1, 0, 0, 0, 0);
      ciclo("rst1", 1, 0, 0, 0, 0);
      ciclo("idle_ign", 0, 0, 1, 1, 1);
      ciclo("start", 0, 1, 0, 0, 0);
      repeat (3) ciclo("turn", 0, 0, 1, 0, 0);
      ciclo("hold", 0, 0, 0, 0, 0);
      // player 2 on move: simultaneous win and move keeps the winner
      ciclo("win_jv", 0, 0, 1, 1, 0);
      repeat (9) ciclo("blink", 0, 0, 1, 1, 1);
      ciclo("restart", 0, 1, 0, 0, 0);
      ciclo("win_fe", 0, 0, 0, 1, 1);
      repeat (4) ciclo("blink2", 0, 0, 0, 0, 0);
      ciclo("mid_restart", 0, 1, 0, 0, 0);
      ciclo("draw", 0, 0, 1, 0, 1);
      repeat (2) ciclo("draw_ign", 0, 0, 1, 1, 0);
      ciclo("from_draw", 0, 1, 0, 0, 0);
      ciclo("jv", 0, 0, 1, 0, 0);
      ciclo("win3", 0, 0, 0, 1, 0);
      repeat (5) ciclo("blink3", 0, 0, 0, 0, 0);
      ciclo("rst_vit", 1, 0, 0, 0, 0);
      ciclo("after_rst", 0, 0, 0, 0, 0);
      repeat (3) begin
         ciclo("game", 0, 1, 0, 0, 0);
         ciclo("game_jv", 0, 0, 1, 0, 0);
      end
      ciclo("play_restart", 0, 1, 1, 1, 0);
      for (int k = 0; k < 600; k++) begin
         bit r, i, jv, fv, fe;
         r  = ($urandom_range(99) < 1);
         i  = ($urandom_range(99) < 4);
         jv = ($urandom_range(99) < 40);
         fv = ($urandom_range(99) < 5);
         fe = ($urandom_range(99) < 5);
         ciclo("rand", r, i, jv, fv, fe);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               comparacoes, erros);
      $finish;
   end

endmodule

// File: doc/indicador_jogador.md
Name: indicador_jogador

Overview:
- Control stage directly upstream of the letter-J 7-segment decoder.
- Tracks game phase and the player whose turn it is.
- Drives the decoder's enable: "J" is shown while a game runs, a blinking "J" marks the winner, and "-" is shown when idle or after a draw.
- Also drives a player-number digit (1/2) toward the numeric hex decoder.

Parameters:
- PERIODO_PISCA, 25000000, clock cycles per blink half-period (0.5 s at 50 MHz); legal range >= 2.
- Counter width: $clog2(PERIODO_PISCA).

Ports:
- clock  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- iniciar  input  1  start/restart game, level-sampled each edge
- jogada_valida  input  1  one-cycle pulse: current player completed a legal move
- fim_vitoria  input  1  one-cycle pulse: the move just made won the game
- fim_empate  input  1  one-cycle pulse: board full, no winner
- habilita_J  output  1  enable to letter-J decoder (1 = "J", 0 = "-")
- jogador_atual  output  1  0 = player 1, 1 = player 2
- numero_jogador  output  4  BCD digit for hex decoder: 0, 1 or 2
- fim_jogo  output  1  high in VITORIA or EMPATE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered or decoded from registered state only. No input-to-output combinational path.
- Response latency: 1 cycle after the sampling edge.
- Reset values:
  - estado = OCIOSO, jogador_atual = 0, contador = 0, fase_pisca = 1.
  - Outputs: habilita_J = 0, numero_jogador = 0, fim_jogo = 0.
- reset overrides every other input in the same cycle, including mid-game and mid-blink.
- States: OCIOSO=2'b00, JOGANDO=2'b01, VITORIA=2'b10, EMPATE=2'b11.
- OCIOSO:
  - habilita_J = 0, numero_jogador = 0.
  - iniciar = 1 -> JOGANDO, jogador_atual <= 0.
  - All other inputs are ignored.
- JOGANDO:
  - habilita_J = 1, numero_jogador = jogador_atual + 1.
  - Input priority, highest first: iniciar > fim_vitoria > fim_empate > jogada_valida.
  - iniciar: stay in JOGANDO, jogador_atual <= 0, contador <= 0.
  - fim_vitoria: -> VITORIA. jogador_atual is frozen (winner = mover), and a simultaneous jogada_valida does not toggle it. contador <= 0, fase_pisca <= 1.
  - fim_empate: -> EMPATE, jogador_atual unchanged.
  - jogada_valida alone: jogador_atual <= ~jogador_atual.
- VITORIA:
  - fim_jogo = 1, numero_jogador = jogador_atual + 1, habilita_J = fase_pisca.
  - contador increments every cycle. At PERIODO_PISCA-1 it wraps to 0 and fase_pisca toggles.
  - First toggle (1 -> 0) occurs PERIODO_PISCA cycles after entry.
  - jogada_valida, fim_vitoria and fim_empate are ignored.
  - iniciar -> JOGANDO, jogador_atual <= 0, contador <= 0, fase_pisca <= 1.
- EMPATE:
  - fim_jogo = 1, habilita_J = 0, numero_jogador = 0.
  - iniciar -> JOGANDO, jogador_atual <= 0.
  - Other inputs are ignored.
- contador holds at 0 outside VITORIA.

Optional Feature:
- Macro: INDICADOR_ALTERNA_INICIO_EN.
- Defined:
  - A register inicio_prox (reset 0) selects the starting player.
  - Every transition into JOGANDO via iniciar loads jogador_atual <= inicio_prox and toggles inicio_prox. This includes a restart from JOGANDO.
  - Result: consecutive games alternate the first player 1, 2, 1, ...
- Undefined: every game starts with jogador_atual = 0; inicio_prox does not exist.

Test Plan (PERIODO_PISCA = 4):
- Reset and start:
  - reset = 1 for 2 cycles -> habilita_J = 0, numero_jogador = 0, fim_jogo = 0.
  - iniciar pulse -> next cycle habilita_J = 1, jogador_atual = 0, numero_jogador = 1.
- Turns: three jogada_valida pulses in JOGANDO -> numero_jogador sequence 1 -> 2 -> 1 -> 2, each one cycle after its pulse.
- Victory:
  - jogador_atual = 1; fim_vitoria and jogada_valida asserted in the same cycle -> VITORIA, numero_jogador = 2, fim_jogo = 1.
  - habilita_J pattern: 1,1,1,1,0,0,0,0,1,... (period 8).
- Draw: fim_empate and fim_vitoria together -> VITORIA (priority); a separate fim_empate alone -> habilita_J = 0, numero_jogador = 0, fim_jogo = 1.
- Restart mid-blink: iniciar at blink cycle 5 in VITORIA -> next cycle JOGANDO, habilita_J = 1, numero_jogador = 1 (macro off) or per inicio_prox (macro on).
- Reset mid-operation and macro:
  - reset while in VITORIA -> all outputs at reset values next cycle.
  - With INDICADOR_ALTERNA_INICIO_EN: three successive iniciar-started games begin with numero_jogador 1, 2, 1.
